// File: rtl/sweep_response_capture.sv
// sweep_response_capture: exhaustive-sweep pattern driver and response capture.
// Drives every N_WIDTH-bit pattern in ascending order, holds each for SETTLE
// cycles plus one sample cycle, and packs the sampled responses into resp_vec.
// Optional golden compare is built only when SWEEP_GOLDEN_CMP_EN is defined;
// otherwise mismatch, fail_count and first_fail_idx are tied to 0.
module sweep_response_capture #(
    parameter int N_WIDTH = 4,
    parameter int SETTLE  = 1
) (
    input  logic                    CK,
    input  logic                    reset,
    input  logic                    start,
    output logic [0:N_WIDTH-1]      N_out,
    input  logic                    resp_in,
    output logic                    busy,
    output logic                    done,
    output logic [2**N_WIDTH-1:0]   resp_vec,
    input  logic [2**N_WIDTH-1:0]   golden,
    output logic                    mismatch,
    output logic [N_WIDTH:0]        fail_count,
    output logic [N_WIDTH-1:0]      first_fail_idx
);

    localparam int NPAT  = 2**N_WIDTH;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [N_WIDTH-1:0] IDX_LAST = N_WIDTH'(NPAT - 1);
    localparam logic [N_WIDTH-1:0] IDX_ONE  = N_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [N_WIDTH-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NPAT-1:0]        resp_vec_q, resp_vec_d;

    // Sweep sequencing: next state, pattern index, settle count and capture.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        resp_vec_d = resp_vec_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SETTLE;
                    idx_d      = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    resp_vec_d = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_SAMPLE: begin
                resp_vec_d[idx_q] = resp_in;
                if (idx_q == IDX_LAST) begin
                    // busy drops and done rises together on entry to DONE
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and capture registers.
    always_ff @(posedge CK) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            resp_vec_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            resp_vec_q <= resp_vec_d;
        end
    end

    // The pattern bus is the index itself; N_out[0] carries the index MSB.
    assign N_out    = idx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign resp_vec = resp_vec_q;

`ifdef SWEEP_GOLDEN_CMP_EN
    logic                   mismatch_q, mismatch_d;
    logic [N_WIDTH:0]       fail_count_q, fail_count_d;
    logic [N_WIDTH-1:0]     first_fail_q, first_fail_d;

    localparam logic [N_WIDTH:0] FC_ONE = (N_WIDTH+1)'(1);

    // Golden compare: clear on an accepted start, update on each sample cycle.
    always_comb begin
        mismatch_d   = mismatch_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        if (state_q == ST_IDLE && start) begin
            mismatch_d   = 1'b0;
            fail_count_d = '0;
            first_fail_d = '0;
        end else if (state_q == ST_SAMPLE && resp_in != golden[idx_q]) begin
            // at most 2**N_WIDTH increments, so N_WIDTH+1 bits never overflow
            fail_count_d = fail_count_q + FC_ONE;
            mismatch_d   = 1'b1;
            if (fail_count_q == '0) begin
                first_fail_d = idx_q;
            end
        end
    end

    // Compare result registers.
    always_ff @(posedge CK) begin
        if (reset) begin
            mismatch_q   <= 1'b0;
            fail_count_q <= '0;
            first_fail_q <= '0;
        end else begin
            mismatch_q   <= mismatch_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    assign mismatch       = mismatch_q;
    assign fail_count     = fail_count_q;
    assign first_fail_idx = first_fail_q;
`else
    // Without the compare, golden has no consumer.
    logic unused_golden;
    assign unused_golden  = ^golden;

    assign mismatch       = 1'b0;
    assign fail_count     = '0;
    assign first_fail_idx = '0;
`endif

endmodule

// File: tb/tb_sweep_response_capture.sv
// Scoreboard bench for sweep_response_capture: two instances (SETTLE=1 and
// SETTLE=3) driven by a parity "benchmark"; expectations are queued at start
// and checked by per-instance monitors whenever done is presented.
module tb_sweep_response_capture;

    localparam int NW = 4;
    localparam int NP = 16;

`ifdef SWEEP_GOLDEN_CMP_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic           CK = 1'b0;
    logic           reset = 1'b1;
    logic           start_a = 1'b0;
    logic           start_b = 1'b0;
    logic [NP-1:0]  golden = '0;

    logic [0:NW-1]  n_a, n_b;
    logic           resp_a, resp_b;
    logic           busy_a, busy_b, done_a, done_b;
    logic [NP-1:0]  rv_a, rv_b;
    logic           mm_a, mm_b;
    logic [NW:0]    fc_a, fc_b;
    logic [NW-1:0]  ff_a, ff_b;

    // Parity benchmark: output_single is XOR of the pattern bits.
    assign resp_a = ^n_a;
    assign resp_b = ^n_b;

    sweep_response_capture #(.N_WIDTH(NW), .SETTLE(1)) dut_a (
        .CK(CK), .reset(reset), .start(start_a), .N_out(n_a), .resp_in(resp_a),
        .busy(busy_a), .done(done_a), .resp_vec(rv_a), .golden(golden),
        .mismatch(mm_a), .fail_count(fc_a), .first_fail_idx(ff_a));

    sweep_response_capture #(.N_WIDTH(NW), .SETTLE(3)) dut_b (
        .CK(CK), .reset(reset), .start(start_b), .N_out(n_b), .resp_in(resp_b),
        .busy(busy_b), .done(done_b), .resp_vec(rv_b), .golden(golden),
        .mismatch(mm_b), .fail_count(fc_b), .first_fail_idx(ff_b));

    always #5 CK = ~CK;

    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [NP-1:0] rv;
        logic          mm;
        logic [NW:0]   fc;
        logic [NW-1:0] ff;
        int            dc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor A: every done pulse must match the oldest queued expectation.
    always @(negedge CK) begin : mon_a
        exp_t e;
        if (done_a) begin
            if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
            else begin
                e = q_a.pop_front();
                chk("a_done_cycle", cyc, e.dc);
                chk("a_busy_at_done", {31'd0, busy_a}, 0);
                chk("a_resp_vec", {16'd0, rv_a}, {16'd0, e.rv});
                chk("a_mismatch", {31'd0, mm_a}, {31'd0, e.mm});
                chk("a_fail_count", {27'd0, fc_a}, {27'd0, e.fc});
                chk("a_first_fail", {28'd0, ff_a}, {28'd0, e.ff});
            end
        end
    end

    // Monitor B: same checks for the SETTLE=3 instance.
    always @(negedge CK) begin : mon_b
        exp_t e;
        if (done_b) begin
            if (q_b.size() == 0) chk("b_unexpected_done", 1, 0);
            else begin
                e = q_b.pop_front();
                chk("b_done_cycle", cyc, e.dc);
                chk("b_busy_at_done", {31'd0, busy_b}, 0);
                chk("b_resp_vec", {16'd0, rv_b}, {16'd0, e.rv});
                chk("b_mismatch", {31'd0, mm_b}, {31'd0, e.mm});
                chk("b_fail_count", {27'd0, fc_b}, {27'd0, e.fc});
                chk("b_first_fail", {28'd0, ff_b}, {28'd0, e.ff});
            end
        end
    end

    // Queue an expectation; called at the negedge where start is raised.
    task automatic push(input bit sel, input logic [NP-1:0] rv, input logic mm,
                        input logic [NW:0] fc, input logic [NW-1:0] ff);
        exp_t e;
        e.rv = rv;
        e.mm = mm;
        e.fc = fc;
        e.ff = ff;
        e.dc = cyc + 1 + NP * ((sel ? 3 : 1) + 1);
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
    endtask

    task automatic wait_idle(input bit sel);
        for (int i = 0; i < 200; i++) begin
            if ((sel ? q_b.size() : q_a.size()) == 0) break;
            @(negedge CK);
        end
        chk(sel ? "b_done_timeout" : "a_done_timeout", sel ? q_b.size() : q_a.size(), 0);
        if (sel) q_b.delete();
        else     q_a.delete();
    endtask

    // One sweep: pulse start, optionally check every pattern step, await done.
    task automatic run(input bit sel, input logic [NP-1:0] g, input logic mm,
                       input logic [NW:0] fc, input logic [NW-1:0] ff, input bit steps);
        int hold;
        hold = sel ? 4 : 2;
        @(negedge CK);
        golden = g;
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        push(sel, 16'h6996, mm, fc, ff);
        @(negedge CK);
        start_a = 1'b0;
        start_b = 1'b0;
        if (steps) begin
            for (int n = 1; n <= NP * hold; n++) begin
                chk(sel ? "b_n_out_step" : "a_n_out_step",
                    sel ? {28'd0, n_b} : {28'd0, n_a}, (n - 1) / hold);
                chk(sel ? "b_busy_step" : "a_busy_step",
                    sel ? {31'd0, busy_b} : {31'd0, busy_a}, 1);
                @(negedge CK);
            end
        end
        wait_idle(sel);
    endtask

    task automatic check_zero_a(input string tag);
        chk({tag, "_n_out"}, {28'd0, n_a}, 0);
        chk({tag, "_busy"}, {31'd0, busy_a}, 0);
        chk({tag, "_done"}, {31'd0, done_a}, 0);
        chk({tag, "_resp_vec"}, {16'd0, rv_a}, 0);
        chk({tag, "_mismatch"}, {31'd0, mm_a}, 0);
        chk({tag, "_fail_count"}, {27'd0, fc_a}, 0);
        chk({tag, "_first_fail"}, {28'd0, ff_a}, 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (3) @(negedge CK);
        check_zero_a("rst");
        chk("rst_b_busy", {31'd0, busy_b}, 0);
        chk("rst_b_resp_vec", {16'd0, rv_b}, 0);
        reset = 1'b0;
        @(negedge CK);

        // Parity sweep with step checks, then results must hold while idle.
        run(1'b0, 16'h6996, 1'b0, 5'd0, 4'd0, 1'b1);
        repeat (5) @(negedge CK);
        chk("a_hold_resp_vec", {16'd0, rv_a}, 32'h6996);
        chk("a_hold_busy", {31'd0, busy_a}, 0);

        // Golden mismatch cases: pattern 0 differs; then every odd-parity pattern.
        run(1'b0, 16'h6997, CMP, CMP ? 5'd1 : 5'd0, 4'd0, 1'b0);
        run(1'b0, 16'h0000, CMP, CMP ? 5'd8 : 5'd0, CMP ? 4'd1 : 4'd0, 1'b0);

        // Reset mid-run while pattern 5 is on the bus: no done may follow.
        @(negedge CK);
        golden = 16'h6996;
        start_a = 1'b1;
        @(negedge CK);
        start_a = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (n_a == 4'd5) break;
            @(negedge CK);
        end
        chk("a_reach_pat5", {28'd0, n_a}, 5);
        reset = 1'b1;
        @(negedge CK);
        check_zero_a("midrst");
        reset = 1'b0;
        repeat (40) @(negedge CK);
        run(1'b0, 16'h6996, 1'b0, 5'd0, 4'd0, 1'b0);

        // Start held high for 20 cycles: exactly one done, in cycle 33.
        @(negedge CK);
        golden = 16'h6996;
        start_a = 1'b1;
        push(1'b0, 16'h6996, 1'b0, 5'd0, 4'd0);
        repeat (20) @(negedge CK);
        start_a = 1'b0;
        wait_idle(1'b0);
        repeat (20) @(negedge CK);

        // SETTLE=3 instance: 4-cycle pattern hold, done in cycle 65.
        run(1'b1, 16'h0000, CMP, CMP ? 5'd8 : 5'd0, CMP ? 4'd1 : 4'd0, 1'b1);
        run(1'b1, 16'hFFFF, CMP, CMP ? 5'd8 : 5'd0, 4'd0, 1'b0);
        repeat (10) @(negedge CK);

        chk("a_queue_empty", q_a.size(), 0);
        chk("b_queue_empty", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
